adc_frame_tx: RTL and testbench
===============================

Name: adc_frame_tx

Overview:
- Transmit-side model of the ADC data interface (DCLK/DRDY plus 5 serial data lanes), clocked from MCLK.
- Drives the same pins the control-domain receive path and timing hub consume.
- Used for hardware loopback and HIL bring-up without the physical ADC: PL pins jumpered, or internal loopback into timing_hub.
- Accepts one multi-lane sample per frame over a valid/ready handshake; serialises it MSB-first with a DRDY strobe per frame.

Parameters:
- N_LANES, 5, number of serial data lanes (one channel per lane)
- SAMPLE_W, 24, bits per channel sample
- DCLK_DIV, 4, mclk cycles per DCLK period; even, >=2
- FRAME_DCLKS, 256, DCLK periods per frame; >= SAMPLE_W+1
- DRDY_DCLKS, 1, DRDY low width in DCLK periods; 1..SAMPLE_W

Ports:
- mclk  in  1  ADC master clock (32.768 MHz)
- rst_n  in  1  async active-low reset
- en  in  1  run enable; low forces IDLE
- sync_req  in  1  one-cycle pulse: abort frame, restart at bit 0
- smp_data  in  N_LANES*SAMPLE_W  lane k in bits [k*SAMPLE_W +: SAMPLE_W]
- smp_valid  in  1  sample available
- smp_ready  out  1  one-cycle accept pulse
- dclk_o  out  1  serial bit clock
- drdy_o  out  1  frame strobe, active low
- dout  out  N_LANES  serial data, MSB first
- frame_start  out  1  one-cycle pulse at frame bit 0
- underrun  out  1  sticky: frame started without a valid sample
- underrun_clr  in  1  clears underrun

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-low; clock mclk. All outputs are registered.
- Reset values: dclk_o=0, drdy_o=1, dout=0, smp_ready=0, frame_start=0, underrun=0. Internal sample register = 0.
- States:
  - IDLE: outputs at reset values, counters at 0.
  - RUN: free-running DCLK.
- Transitions:
  - IDLE->RUN when en=1.
  - RUN->IDLE when en=0. The effect is immediate on the next mclk edge, mid-frame included; there is no flush.
- Counters:
  - div_cnt runs 0..DCLK_DIV-1.
  - bit_cnt runs 0..FRAME_DCLKS-1 and increments when div_cnt wraps; it wraps to 0, which starts a new frame.
- DCLK: dclk_o=0 for div_cnt < DCLK_DIV/2, 1 otherwise.
- Data launch and timing:
  - Data launches on the falling edge (the div_cnt==0 update) and is sampled by the receiver on the rising edge.
  - The first mclk after IDLE->RUN is div_cnt=0, bit_cnt=0.
- Frame start (div_cnt==0, bit_cnt==0), all in the same mclk edge:
  - frame_start=1.
  - drdy_o=0.
  - If smp_valid=1: capture smp_data and pulse smp_ready. Otherwise reuse the previous sample and set underrun.
  - The MSB of each lane goes onto dout.
- Per bit period:
  - Bit periods 0..SAMPLE_W-1: dout[k] = lane k bit (SAMPLE_W-1-bit_cnt).
  - Later periods: dout=0.
- DRDY: drdy_o returns to 1 at the div_cnt==0 edge of bit period DRDY_DCLKS.
- Simultaneous events:
  - sync_req has priority over the frame-boundary logic and is ignored in IDLE.
  - sync_req in RUN: the next edge behaves as a frame start (div_cnt=0, bit_cnt=0).
  - underrun_clr and a new underrun in the same cycle: underrun stays 1 (set wins).
- smp_ready is never asserted outside a frame start; a held smp_valid is consumed at most once per frame.

Optional Feature:
- Macro: ADC_TX_CRC_EN.
- Defined:
  - Each lane appends CRC-8 (poly 0x07, init 0x00, MSB first) over its SAMPLE_W sample bits.
  - The CRC is sent in bit periods SAMPLE_W..SAMPLE_W+7.
  - Requires FRAME_DCLKS >= SAMPLE_W+9; violation is caught by an elaboration-time check.
- Undefined: those periods carry 0, and no CRC logic is built.

Decomposition:
- Package esc_adc_pkg:
  - N_LANES and SAMPLE_W defaults
  - CRC8_POLY = 8'h07
  - typedef enum logic {IDLE, RUN} adc_tx_state_t
  - sample-word typedef logic [SAMPLE_W-1:0] adc_sample_t
- Sub-module adc_tx_lane, instantiated N_LANES times:
  - per-lane load/shift register
  - CRC accumulator under the macro

Test Plan:
- Defaults with FRAME_DCLKS=32, smp_valid held, lane0=24'hA5C3F0, lane4=24'h000001 -> dclk_o period 4 mclk at 50% duty; drdy_o low for exactly 4 mclk per 128-mclk frame; lane0 bits 101001011100001111110000 sampled on rising edges; lane4 LSB=1 in bit 23; dout=0 in bits 24..31.
- smp_valid low at second frame start -> smp_ready not pulsed, previous sample retransmitted, underrun=1 until the underrun_clr pulse; simultaneous clr+underrun keeps 1.
- sync_req at bit_cnt=10 -> next edge: frame_start=1, drdy_o=0, MSB of the new sample on dout; the remaining bits of the aborted frame are never sent.
- en dropped at bit_cnt=5 -> next edge dclk_o=0, drdy_o=1, dout=0; re-enable -> frame starts at bit 0 on the first edge.
- rst_n asserted mid-frame (asynchronously, between mclk edges) -> all outputs at reset values immediately; after release with en=1 the first frame starts on the first mclk.
- ADC_TX_CRC_EN, lane0=24'h000001 -> bits 24..31 carry CRC-8 0x07 (00000111); bench reference CRC matches for 1000 random samples.

Source files
------------

// File: rtl/esc_adc_pkg.sv
// ---------------------------------------------------------------------------
// esc_adc_pkg
// Shared definitions for the ADC transmit-side model (adc_frame_tx and its
// per-lane serialiser adc_tx_lane).
//   ADC_N_LANES / ADC_SAMPLE_W : default lane count and sample width
//   CRC8_POLY                  : CRC-8 polynomial used when ADC_TX_CRC_EN is
//                                defined
//   adc_tx_state_t             : transmitter state
//   adc_sample_t               : one channel sample at the default width
//   crc8_step                  : one MSB-first CRC-8 update for a single bit
// ---------------------------------------------------------------------------
package esc_adc_pkg;

   localparam int ADC_N_LANES  = 5;
   localparam int ADC_SAMPLE_W = 24;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef enum logic {IDLE, RUN} adc_tx_state_t;

   typedef logic [ADC_SAMPLE_W-1:0] adc_sample_t;

   // Feeds one message bit into the CRC register, MSB first, no reflection.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                            input logic       bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/adc_tx_lane.sv
// ---------------------------------------------------------------------------
// adc_tx_lane
// One serial data lane: holds the captured sample, loads a shift register
// at each frame start and launches one bit per DCLK period, MSB first.
// Build option ADC_TX_CRC_EN: a CRC-8 over the sample bits is accumulated
// while shifting and sent in the eight periods after the sample.
// Ports:
//   mclk, rst_n : clock, async active-low reset
//   clear       : transmitter idle on this edge, dout forced to 0
//   start       : frame-start launch edge (bit period 0)
//   capture     : take smp_in as the new sample (only with start)
//   launch      : falling-DCLK launch edge of a later bit period
//   bit_idx     : bit period being launched
//   smp_in      : new sample for this lane
//   dout        : registered serial data
// ---------------------------------------------------------------------------
module adc_tx_lane
   import esc_adc_pkg::*;
#(
   parameter int SAMPLE_W = ADC_SAMPLE_W,
   parameter int BIT_W    = 8
) (
   input  logic                mclk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                start,
   input  logic                capture,
   input  logic                launch,
   input  logic [BIT_W-1:0]    bit_idx,
   input  logic [SAMPLE_W-1:0] smp_in,
   output logic                dout
);

   logic [SAMPLE_W-1:0] sample_q;
   logic [SAMPLE_W-1:0] shift_q;
   logic [SAMPLE_W-1:0] src;

   // A frame without a fresh sample retransmits the last one captured.
   assign src = capture ? smp_in : sample_q;

`ifdef ADC_TX_CRC_EN
   logic [7:0] crc_q;

   // CRC register tracks the bits already launched; once the sample is out
   // it holds the finished CRC and is shifted out MSB first.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= 8'h00;
      end else if (clear) begin
         crc_q <= 8'h00;
      end else if (start) begin
         crc_q <= crc8_step(8'h00, src[SAMPLE_W-1]);
      end else if (launch) begin
         if (32'(bit_idx) < SAMPLE_W) begin
            crc_q <= crc8_step(crc_q, shift_q[SAMPLE_W-1]);
         end else if (32'(bit_idx) < SAMPLE_W + 8) begin
            crc_q <= {crc_q[6:0], 1'b0};
         end
      end
   end
`endif

   // Bit 0 comes straight from the sample, the remainder from the shifter,
   // so the shifter is loaded already advanced by one position.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         sample_q <= '0;
         shift_q  <= '0;
         dout     <= 1'b0;
      end else if (clear) begin
         dout <= 1'b0;
      end else if (start) begin
         if (capture) begin
            sample_q <= smp_in;
         end
         shift_q <= src << 1;
         dout    <= src[SAMPLE_W-1];
      end else if (launch) begin
         if (32'(bit_idx) < SAMPLE_W) begin
            dout    <= shift_q[SAMPLE_W-1];
            shift_q <= shift_q << 1;
`ifdef ADC_TX_CRC_EN
         end else if (32'(bit_idx) < SAMPLE_W + 8) begin
            dout <= crc_q[7];
`endif
         end else begin
            dout <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/adc_frame_tx.sv
// ---------------------------------------------------------------------------
// adc_frame_tx
// Transmit-side model of the ADC data interface, clocked from MCLK. Takes
// one multi-lane sample per frame over valid/ready and serialises every
// lane MSB first, with DCLK and an active-low DRDY strobe per frame.
// Build option ADC_TX_CRC_EN appends a per-lane CRC-8 after the sample.
// Ports:
//   mclk, rst_n   : master clock, async active-low reset
//   en            : run enable, low forces idle
//   sync_req      : one-cycle pulse, abort the frame and restart at bit 0
//   smp_data      : lane k in bits [k*SAMPLE_W +: SAMPLE_W]
//   smp_valid     : sample available
//   smp_ready     : one-cycle accept pulse at a frame start
//   dclk_o        : serial bit clock (data launched on its falling edge)
//   drdy_o        : frame strobe, active low
//   dout          : serial data, one bit per lane
//   frame_start   : one-cycle pulse at frame bit 0
//   underrun      : sticky, a frame started without a valid sample
//   underrun_clr  : clears underrun (a simultaneous new underrun wins)
// ---------------------------------------------------------------------------
module adc_frame_tx
   import esc_adc_pkg::*;
#(
   parameter int N_LANES     = ADC_N_LANES,
   parameter int SAMPLE_W    = ADC_SAMPLE_W,
   parameter int DCLK_DIV    = 4,
   parameter int FRAME_DCLKS = 256,
   parameter int DRDY_DCLKS  = 1
) (
   input  logic                        mclk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        sync_req,
   input  logic [N_LANES*SAMPLE_W-1:0] smp_data,
   input  logic                        smp_valid,
   output logic                        smp_ready,
   output logic                        dclk_o,
   output logic                        drdy_o,
   output logic [N_LANES-1:0]          dout,
   output logic                        frame_start,
   output logic                        underrun,
   input  logic                        underrun_clr
);

   localparam int DIV_W = $clog2(DCLK_DIV);
   localparam int BIT_W = $clog2(FRAME_DCLKS);

   if (DCLK_DIV < 2 || (DCLK_DIV % 2) != 0) begin : g_bad_div
      $error("adc_frame_tx: DCLK_DIV must be even and >= 2");
   end
   if (FRAME_DCLKS < SAMPLE_W + 1) begin : g_bad_frame
      $error("adc_frame_tx: FRAME_DCLKS must be >= SAMPLE_W+1");
   end
   if (DRDY_DCLKS < 1 || DRDY_DCLKS > SAMPLE_W) begin : g_bad_drdy
      $error("adc_frame_tx: DRDY_DCLKS must be in 1..SAMPLE_W");
   end
`ifdef ADC_TX_CRC_EN
   if (FRAME_DCLKS < SAMPLE_W + 9) begin : g_bad_crc_frame
      $error("adc_frame_tx: ADC_TX_CRC_EN needs FRAME_DCLKS >= SAMPLE_W+9");
   end
`endif

   adc_tx_state_t    state;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;

   logic [DIV_W-1:0] div_nxt;
   logic [BIT_W-1:0] bit_nxt;
   logic             run_nxt;
   logic             frame_edge;
   logic             launch_edge;
   logic             capture;

   // Position (div_cnt, bit_cnt) the transmitter moves to on this edge. The
   // registered outputs are computed from this next position, so outputs
   // and counters always describe the same mclk period. Entering RUN and a
   // sync_req both land on position (0,0), i.e. a frame start.
   always_comb begin
      run_nxt = en;
      div_nxt = '0;
      bit_nxt = '0;
      if (en && state == RUN && !sync_req) begin
         if (div_cnt == DIV_W'(DCLK_DIV - 1)) begin
            if (bit_cnt != BIT_W'(FRAME_DCLKS - 1)) begin
               bit_nxt = bit_cnt + BIT_W'(1);
            end
         end else begin
            div_nxt = div_cnt + DIV_W'(1);
            bit_nxt = bit_cnt;
         end
      end
   end

   assign launch_edge = run_nxt && (div_nxt == '0);
   assign frame_edge  = launch_edge && (bit_nxt == '0);
   assign capture     = frame_edge && smp_valid;

   // State, counters and all non-data outputs. Dropping en returns every
   // output to its reset value on the very next edge, mid-frame included.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         dclk_o      <= 1'b0;
         drdy_o      <= 1'b1;
         smp_ready   <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (en)  state <= RUN;
            RUN:  if (!en) state <= IDLE;
            default:       state <= IDLE;
         endcase

         div_cnt     <= div_nxt;
         bit_cnt     <= bit_nxt;
         smp_ready   <= capture;
         frame_start <= frame_edge;

         if (!run_nxt) begin
            dclk_o   <= 1'b0;
            drdy_o   <= 1'b1;
            underrun <= 1'b0;
         end else begin
            dclk_o <= (div_nxt >= DIV_W'(DCLK_DIV / 2));
            if (frame_edge) begin
               drdy_o <= 1'b0;
            end else if (launch_edge && bit_nxt == BIT_W'(DRDY_DCLKS)) begin
               drdy_o <= 1'b1;
            end
            if (frame_edge && !smp_valid) begin
               underrun <= 1'b1;
            end else if (underrun_clr) begin
               underrun <= 1'b0;
            end
         end
      end
   end

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      adc_tx_lane #(
         .SAMPLE_W (SAMPLE_W),
         .BIT_W    (BIT_W)
      ) u_lane (
         .mclk    (mclk),
         .rst_n   (rst_n),
         .clear   (!run_nxt),
         .start   (frame_edge),
         .capture (capture),
         .launch  (launch_edge),
         .bit_idx (bit_nxt),
         .smp_in  (smp_data[k*SAMPLE_W +: SAMPLE_W]),
         .dout    (dout[k])
      );
   end

endmodule

// File: tb/tb_adc_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_adc_frame_tx
// Directed and randomised bench for adc_frame_tx with a short frame
// (FRAME_DCLKS=32). Expected outputs come from a frame-time model: the
// number of mclk edges since the last frame start gives the DCLK phase,
// bit period, DRDY level and the bit each lane should be carrying.
// Honours ADC_TX_CRC_EN for the CRC periods.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_frame_tx;
   import esc_adc_pkg::*;

   localparam int N_LANES     = 5;
   localparam int SAMPLE_W    = 24;
   localparam int DCLK_DIV    = 4;
   localparam int FRAME_DCLKS = 32;
   localparam int DRDY_DCLKS  = 1;
   localparam int FRAME_MCLKS = DCLK_DIV * FRAME_DCLKS;

   logic                        mclk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        en = 1'b0;
   logic                        sync_req = 1'b0;
   logic [N_LANES*SAMPLE_W-1:0] smp_data = '0;
   logic                        smp_valid = 1'b0;
   logic                        underrun_clr = 1'b0;
   logic                        smp_ready;
   logic                        dclk_o;
   logic                        drdy_o;
   logic [N_LANES-1:0]          dout;
   logic                        frame_start;
   logic                        underrun;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model state
   bit                          mRun;
   int                          mT;
   logic [N_LANES*SAMPLE_W-1:0] mSample;
   logic                        mUnderrun;
   logic                        expDclk, expDrdy, expReady, expFs;
   logic [N_LANES-1:0]          expDout;

   // Receiver-side observation of the serial stream
   logic [31:0] rx0, rx4;
   logic        prevDclk;
   int          drdyLow;

   adc_frame_tx #(
      .N_LANES     (N_LANES),
      .SAMPLE_W    (SAMPLE_W),
      .DCLK_DIV    (DCLK_DIV),
      .FRAME_DCLKS (FRAME_DCLKS),
      .DRDY_DCLKS  (DRDY_DCLKS)
   ) dut (
      .mclk         (mclk),
      .rst_n        (rst_n),
      .en           (en),
      .sync_req     (sync_req),
      .smp_data     (smp_data),
      .smp_valid    (smp_valid),
      .smp_ready    (smp_ready),
      .dclk_o       (dclk_o),
      .drdy_o       (drdy_o),
      .dout         (dout),
      .frame_start  (frame_start),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   always #5 mclk = ~mclk;

   // Watchdog so the run always ends
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog expired, observed no end of test, expected end of test");
      $fatal(1, "[TB] watchdog");
   end

   // CRC-8 by polynomial long division of sample * x^8 by x^8+x^2+x+1.
   function automatic logic [7:0] crcRef(input adc_sample_t s);
      logic [SAMPLE_W+7:0] r;
      r = {s, 8'h00};
      for (int i = SAMPLE_W + 7; i >= 8; i--) begin
         if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      end
      return r[7:0];
   endfunction

   function automatic logic [7:0] trailerRef(input adc_sample_t s);
`ifdef ADC_TX_CRC_EN
      return crcRef(s);
`else
      return 8'h00 & {8{s[0]}};
`endif
   endfunction

   // Bit carried by lane k during bit period b of a frame.
   function automatic logic expBit(input int k, input int b);
      adc_sample_t s;
      logic [7:0]  c;
      s = mSample[k*SAMPLE_W +: SAMPLE_W];
      c = trailerRef(s);
      if (b < SAMPLE_W) return s[SAMPLE_W-1-b];
      if (b < SAMPLE_W + 8) return c[7-(b-SAMPLE_W)];
      return 1'b0;
   endfunction

   function automatic logic [N_LANES-1:0] msbsOf(input logic [N_LANES*SAMPLE_W-1:0] d);
      logic [N_LANES-1:0] m;
      for (int k = 0; k < N_LANES; k++) m[k] = d[k*SAMPLE_W + SAMPLE_W - 1];
      return m;
   endfunction

   task automatic modelReset();
      mRun      = 0;
      mT        = 0;
      mSample   = '0;
      mUnderrun = 1'b0;
      expDclk   = 1'b0;
      expDrdy   = 1'b1;
      expDout   = '0;
      expReady  = 1'b0;
      expFs     = 1'b0;
   endtask

   // Advance the model by one mclk edge using the inputs present at it.
   task automatic modelEdge();
      int b;
      if (!en) begin
         mRun      = 0;
         mT        = 0;
         mUnderrun = 1'b0;
         expDclk   = 1'b0;
         expDrdy   = 1'b1;
         expDout   = '0;
         expReady  = 1'b0;
         expFs     = 1'b0;
      end else begin
         if (!mRun || sync_req) mT = 0;
         else                   mT = (mT + 1) % FRAME_MCLKS;
         mRun     = 1;
         b        = mT / DCLK_DIV;
         expDclk  = ((mT % DCLK_DIV) >= DCLK_DIV / 2);
         expFs    = (mT == 0);
         expReady = expFs && smp_valid;
         if (mT == 0 && smp_valid) mSample = smp_data;
         if (mT == 0 && !smp_valid) mUnderrun = 1'b1;
         else if (underrun_clr)     mUnderrun = 1'b0;
         expDrdy = !(b < DRDY_DCLKS);
         for (int k = 0; k < N_LANES; k++) expDout[k] = expBit(k, b);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic s, input logic v,
                                input logic [N_LANES*SAMPLE_W-1:0] d,
                                input logic c);
      en           = e;
      sync_req     = s;
      smp_valid    = v;
      smp_data     = d;
      underrun_clr = c;
   endtask

   task automatic checkOutput(input string tag);
      assertCount++;
      assert (dclk_o === expDclk) else begin
         failCount++;
         $error("[TB] FAIL %s dclk_o observed %b expected %b", tag, dclk_o, expDclk);
      end
      assertCount++;
      assert (drdy_o === expDrdy) else begin
         failCount++;
         $error("[TB] FAIL %s drdy_o observed %b expected %b", tag, drdy_o, expDrdy);
      end
      assertCount++;
      assert (dout === expDout) else begin
         failCount++;
         $error("[TB] FAIL %s dout observed %b expected %b", tag, dout, expDout);
      end
      assertCount++;
      assert (smp_ready === expReady) else begin
         failCount++;
         $error("[TB] FAIL %s smp_ready observed %b expected %b", tag, smp_ready, expReady);
      end
      assertCount++;
      assert (frame_start === expFs) else begin
         failCount++;
         $error("[TB] FAIL %s frame_start observed %b expected %b", tag, frame_start, expFs);
      end
      assertCount++;
      assert (underrun === mUnderrun) else begin
         failCount++;
         $error("[TB] FAIL %s underrun observed %b expected %b", tag, underrun, mUnderrun);
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One mclk edge: update the model, then sample the DUT 1 ns later.
   task automatic tick(input string tag);
      @(posedge mclk);
      modelEdge();
      #1;
      checkOutput(tag);
      if (!prevDclk && dclk_o) begin
         rx0 = {rx0[30:0], dout[0]};
         rx4 = {rx4[30:0], dout[4]};
      end
      prevDclk = dclk_o;
      if (frame_start) drdyLow = 0;
      if (!drdy_o) drdyLow++;
   endtask

   // Run until the model sits at frame time t, bounded by two frames.
   task automatic runTo(input int t, input string tag);
      for (int i = 0; i < 2 * FRAME_MCLKS; i++) begin
         if (mRun && mT == t) return;
         tick(tag);
      end
      checkVal({tag, "_reach"}, 32'(mT), 32'(t));
   endtask

   logic [N_LANES*SAMPLE_W-1:0] dataA, dataB, dataC;

   initial begin
      modelReset();
      rx0      = '0;
      rx4      = '0;
      prevDclk = 1'b0;
      drdyLow  = 0;
      dataA = {24'h000001, 24'h0F0F0F, 24'hFEDCBA, 24'h123456, 24'hA5C3F0};
      dataB = {24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h5A5A5A};
      dataC = {24'hC0FFEE, 24'h0BEEF0, 24'h7E57ED, 24'h00FF00, 24'h3C96E1};

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      #12;
      checkOutput("reset");
      @(negedge mclk);
      rst_n = 1'b1;

      // First frame on the first enabled edge, sample held valid
      applyStimulus(1'b1, 1'b0, 1'b1, dataA, 1'b0);
      tick("first_edge");
      checkVal("first_fs", 32'(frame_start), 32'd1);
      checkVal("first_msbs", 32'(dout), 32'b00101);
      runTo(FRAME_MCLKS - 1, "frame1");
      checkVal("lane0_word", rx0, {24'hA5C3F0, trailerRef(24'hA5C3F0)});
`ifdef ADC_TX_CRC_EN
      checkVal("lane4_word", rx4, {24'h000001, 8'h07});
`else
      checkVal("lane4_word", rx4, {24'h000001, 8'h00});
`endif
      checkVal("drdy_low_mclks", 32'(drdyLow), 32'(DRDY_DCLKS * DCLK_DIV));
      tick("frame2_start");
      runTo(FRAME_MCLKS - 1, "frame2");
      checkVal("lane0_word2", rx0, {24'hA5C3F0, trailerRef(24'hA5C3F0)});

      // Underrun: no valid sample at the frame start
      applyStimulus(1'b1, 1'b0, 1'b0, dataB, 1'b0);
      tick("underrun_start");
      checkVal("underrun_set", 32'(underrun), 32'd1);
      checkVal("underrun_no_ready", 32'(smp_ready), 32'd0);
      runTo(FRAME_MCLKS - 1, "underrun_frame");
      checkVal("lane0_reused", rx0, {24'hA5C3F0, trailerRef(24'hA5C3F0)});
      runTo(50, "to_clr");
      applyStimulus(1'b1, 1'b0, 1'b0, dataB, 1'b1);
      tick("clr");
      applyStimulus(1'b1, 1'b0, 1'b0, dataB, 1'b0);
      checkVal("underrun_cleared", 32'(underrun), 32'd0);
      runTo(FRAME_MCLKS - 1, "to_clr_set");
      applyStimulus(1'b1, 1'b0, 1'b0, dataB, 1'b1);
      tick("clr_and_set");
      applyStimulus(1'b1, 1'b0, 1'b1, dataB, 1'b0);
      checkVal("set_wins", 32'(underrun), 32'd1);

      // sync_req at bit period 10 aborts the frame
      runTo(10 * DCLK_DIV + 1, "to_sync");
      applyStimulus(1'b1, 1'b1, 1'b1, dataC, 1'b0);
      tick("sync");
      applyStimulus(1'b1, 1'b0, 1'b1, dataC, 1'b0);
      checkVal("sync_fs", 32'(frame_start), 32'd1);
      checkVal("sync_drdy", 32'(drdy_o), 32'd0);
      checkVal("sync_msbs", 32'(dout), 32'(msbsOf(dataC)));
      runTo(FRAME_MCLKS - 1, "sync_frame");
      checkVal("lane0_sync_word", rx0, {24'h3C96E1, trailerRef(24'h3C96E1)});

      // en dropped at bit period 5, then re-enabled
      runTo(5 * DCLK_DIV + 1, "to_en_drop");
      applyStimulus(1'b0, 1'b0, 1'b1, dataC, 1'b0);
      tick("en_drop");
      checkVal("en_drop_out", {29'd0, dclk_o, drdy_o, |dout}, 32'b010);
      tick("idle1");
      tick("idle2");
      applyStimulus(1'b1, 1'b0, 1'b1, dataA, 1'b0);
      tick("reenable");
      checkVal("reenable_fs", 32'(frame_start), 32'd1);

      // Asynchronous reset mid-frame
      runTo(40, "to_async_rst");
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_rst");
      @(negedge mclk);
      rst_n = 1'b1;
      prevDclk = 1'b0;
      tick("post_rst");
      checkVal("post_rst_fs", 32'(frame_start), 32'd1);
      runTo(FRAME_MCLKS - 1, "post_rst_frame");
      checkVal("lane0_post_rst", rx0, {24'hA5C3F0, trailerRef(24'hA5C3F0)});

      // Randomised traffic against the model
      $display("[TB] random phase");
      for (int c = 0; c < 150 * FRAME_MCLKS; c++) begin
         en           = ($urandom_range(0, 499) != 0);
         sync_req     = ($urandom_range(0, 299) == 0);
         smp_valid    = ($urandom_range(0, 3) != 0);
         underrun_clr = ($urandom_range(0, 49) == 0);
         for (int k = 0; k < N_LANES; k++) begin
            smp_data[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
         end
         tick("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
